// File: rtl/fifo_stream_reader_if.sv
// Port bundle for fifo_stream_reader: the async_fifo show-ahead read side plus the
// narrow valid/ready beat stream and the drained-word counter.
interface fifo_stream_reader_if #(
   parameter int WIDTH     = 32,
   parameter int RATIO     = 4,
   parameter int CNT_WIDTH = 16
);
   localparam int OUT_WIDTH = WIDTH / RATIO;

   logic                 fifo_empty;
   logic [WIDTH-1:0]     fifo_data;
   logic                 fifo_read_en;
   logic                 out_valid;
   logic                 out_ready;
   logic [OUT_WIDTH-1:0] out_data;
   logic                 out_last;
   logic [CNT_WIDTH-1:0] words_drained;

   modport master (
      input  fifo_empty,
      input  fifo_data,
      input  out_ready,
      output fifo_read_en,
      output out_valid,
      output out_data,
      output out_last,
      output words_drained
   );

   modport slave (
      output fifo_empty,
      output fifo_data,
      output out_ready,
      input  fifo_read_en,
      input  out_valid,
      input  out_data,
      input  out_last,
      input  words_drained
   );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side drain engine: pops WIDTH-bit words from a show-ahead FIFO and streams each
// one out as RATIO narrower beats, LSB beat first, at up to one beat per clock.
module fifo_stream_reader #(
   parameter int WIDTH     = 32,
   parameter int RATIO     = 4,
   parameter int CNT_WIDTH = 16
) (
   input logic                  read_clk,
   input logic                  read_reset,
   fifo_stream_reader_if.master bus
);
   localparam int OUT_WIDTH = WIDTH / RATIO;
   localparam int IDX_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(RATIO - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [WIDTH-1:0]     word_buf;
   logic [IDX_WIDTH-1:0] beat_idx;
   logic [CNT_WIDTH-1:0] words_drained;
   logic [OUT_WIDTH-1:0] out_data_c;
   logic                 out_valid;
   logic                 is_last;
   logic                 handshake;
   logic                 last_hs;
   logic                 pop;

   assign out_valid = (state == SHIFT);
   assign is_last   = (beat_idx == LAST_IDX);
   assign handshake = out_valid && bus.out_ready;
   assign last_hs   = handshake && is_last;

   always_ff @(posedge read_clk or posedge read_reset) begin
      if (read_reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A new word is fetched either when nothing is held or on the very edge the last beat
   // leaves, which is what keeps the beat stream free of bubbles between words.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (!bus.fifo_empty) begin
               pop        = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (last_hs) begin
               if (!bus.fifo_empty) begin
                  pop = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
      if (read_reset) begin
         pop        = 1'b0;
         state_next = IDLE;
      end
   end

   always_ff @(posedge read_clk or posedge read_reset) begin
      if (read_reset) begin
         word_buf      <= '0;
         beat_idx      <= '0;
         words_drained <= '0;
      end else if (pop) begin
         word_buf      <= bus.fifo_data;
         beat_idx      <= '0;
         words_drained <= words_drained + CNT_WIDTH'(1);
      end else if (handshake && !is_last) begin
         beat_idx <= beat_idx + IDX_WIDTH'(1);
      end
   end

   always_comb begin
      out_data_c = '0;
      for (int i = 0; i < RATIO; i++) begin
         if (beat_idx == IDX_WIDTH'(i)) begin
            out_data_c = word_buf[i*OUT_WIDTH +: OUT_WIDTH];
         end
      end
   end

   assign bus.fifo_read_en  = pop;
   assign bus.out_valid     = out_valid;
   assign bus.out_data      = out_data_c;
   assign bus.out_last      = is_last;
   assign bus.words_drained = words_drained;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a RATIO=4 build and a RATIO=1 build driven side by side,
// each checked every cycle against a FIFO queue and an expected-beat queue.
module tb_fifo_stream_reader;
   logic read_clk = 1'b0;
   logic read_reset;

   always #5 read_clk = ~read_clk;

   fifo_stream_reader_if #(.WIDTH(32), .RATIO(4), .CNT_WIDTH(16)) busA ();
   fifo_stream_reader_if #(.WIDTH(8),  .RATIO(1), .CNT_WIDTH(4))  busB ();

   fifo_stream_reader #(.WIDTH(32), .RATIO(4), .CNT_WIDTH(16)) dutA (
      .read_clk   (read_clk),
      .read_reset (read_reset),
      .bus        (busA.master)
   );

   fifo_stream_reader #(.WIDTH(8), .RATIO(1), .CNT_WIDTH(4)) dutB (
      .read_clk   (read_clk),
      .read_reset (read_reset),
      .bus        (busB.master)
   );

   int checks = 0;
   int errors = 0;

   // Index 0 models the RATIO=4 build, index 1 the RATIO=1 build; both emit 8-bit beats.
   int          ratioOf [2] = '{4, 1};
   int unsigned cntMod  [2] = '{65536, 16};
   bit [31:0]   fifoQ   [2][$];
   bit [8:0]    beatQ   [2][$];
   int unsigned drained [2];
   bit          readyIn [2];

   task automatic checkVal(input string name, input logic [32:0] actual, input logic [32:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic bit modelReadEn(input int k, input bit rst);
      bit holding = beatQ[k].size() > 0;
      if (rst) return 1'b0;
      return (fifoQ[k].size() > 0) && (!holding || (readyIn[k] && beatQ[k].size() == 1));
   endfunction

   task automatic checkInst(input int k, input bit rst, input logic v, input logic [7:0] d,
                            input logic l, input logic re, input logic [15:0] cnt);
      bit holding = beatQ[k].size() > 0;
      checkVal($sformatf("inst%0d out_valid", k), {32'd0, v}, {32'd0, holding});
      if (holding) begin
         checkVal($sformatf("inst%0d out_data", k), {25'd0, d}, {25'd0, beatQ[k][0][7:0]});
         checkVal($sformatf("inst%0d out_last", k), {32'd0, l}, {32'd0, beatQ[k][0][8]});
      end
      checkVal($sformatf("inst%0d fifo_read_en", k), {32'd0, re}, {32'd0, modelReadEn(k, rst)});
      checkVal($sformatf("inst%0d words_drained", k), {17'd0, cnt}, 33'(drained[k]));
   endtask

   task automatic checkOutput(input bit rst);
      checkInst(0, rst, busA.out_valid, busA.out_data, busA.out_last, busA.fifo_read_en,
                16'(busA.words_drained));
      checkInst(1, rst, busB.out_valid, busB.out_data, busB.out_last, busB.fifo_read_en,
                16'(busB.words_drained));
   endtask

   // One clock: drive inputs after the falling edge, check, then advance the model to the
   // state the next rising edge must produce.
   task automatic applyStimulus(input bit rdyA, input bit rdyB, input bit rst);
      @(negedge read_clk);
      read_reset     = rst;
      readyIn[0]     = rdyA;
      readyIn[1]     = rdyB;
      busA.out_ready = rdyA;
      busB.out_ready = rdyB;
      busA.fifo_empty = (fifoQ[0].size() == 0);
      busA.fifo_data  = (fifoQ[0].size() == 0) ? $urandom : fifoQ[0][0];
      busB.fifo_empty = (fifoQ[1].size() == 0);
      busB.fifo_data  = (fifoQ[1].size() == 0) ? 8'($urandom) : fifoQ[1][0][7:0];
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            beatQ[k].delete();
            drained[k] = 0;
         end
      end
      #1;
      checkOutput(rst);
      if (!rst) begin
         for (int k = 0; k < 2; k++) begin
            bit re = modelReadEn(k, 1'b0);
            if (beatQ[k].size() > 0 && readyIn[k]) void'(beatQ[k].pop_front());
            if (re) begin
               bit [31:0] w = fifoQ[k].pop_front();
               for (int b = 0; b < ratioOf[k]; b++) begin
                  beatQ[k].push_back({b == ratioOf[k] - 1, w[b*8 +: 8]});
               end
               drained[k] = (drained[k] + 1) % cntMod[k];
            end
         end
      end
   endtask

   logic [7:0] twoWords [8] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};

   initial begin
      read_reset      = 1'b1;
      busA.out_ready  = 1'b0;
      busB.out_ready  = 1'b0;
      busA.fifo_empty = 1'b1;
      busB.fifo_empty = 1'b1;
      busA.fifo_data  = '0;
      busB.fifo_data  = '0;

      // Reset holds read enable low even with a word waiting.
      fifoQ[0].push_back(32'hDDCCBBAA);
      applyStimulus(1, 1, 1);
      checkVal("lit reset fifo_read_en", {32'd0, busA.fifo_read_en}, 33'd0);
      checkVal("lit reset out_valid", {32'd0, busA.out_valid}, 33'd0);
      checkVal("lit reset words_drained", {17'd0, busA.words_drained}, 33'd0);
      applyStimulus(1, 1, 1);

      // Single word: pop, then AA BB CC DD on consecutive cycles.
      applyStimulus(1, 1, 0);
      checkVal("lit single pop", {32'd0, busA.fifo_read_en}, 33'd1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 1, 0);
         checkVal($sformatf("lit single beat%0d", i), {25'd0, busA.out_data}, {25'd0, twoWords[i]});
         checkVal($sformatf("lit single last%0d", i), {32'd0, busA.out_last}, {32'd0, i == 3});
      end
      applyStimulus(1, 1, 0);
      checkVal("lit single idle", {32'd0, busA.out_valid}, 33'd0);
      checkVal("lit single count", {17'd0, busA.words_drained}, 33'd1);

      // Two queued words stream back to back; second pop coincides with the DD handshake.
      fifoQ[0].push_back(32'hDDCCBBAA);
      fifoQ[0].push_back(32'h44332211);
      applyStimulus(1, 1, 0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1, 1, 0);
         checkVal($sformatf("lit pair beat%0d", i), {25'd0, busA.out_data}, {25'd0, twoWords[i]});
         checkVal($sformatf("lit pair valid%0d", i), {32'd0, busA.out_valid}, 33'd1);
         if (i == 3) checkVal("lit pair second pop", {32'd0, busA.fifo_read_en}, 33'd1);
      end
      applyStimulus(1, 1, 0);
      checkVal("lit pair count", {17'd0, busA.words_drained}, 33'd3);

      // Backpressure on BB with another word waiting: no pop, beat held.
      fifoQ[0].push_back(32'hDDCCBBAA);
      applyStimulus(1, 1, 0);
      applyStimulus(1, 1, 0);
      fifoQ[0].push_back(32'h44332211);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1, 0);
         checkVal("lit stall data", {25'd0, busA.out_data}, 33'hBB);
         checkVal("lit stall valid", {32'd0, busA.out_valid}, 33'd1);
         checkVal("lit stall read_en", {32'd0, busA.fifo_read_en}, 33'd0);
      end
      applyStimulus(1, 1, 0);
      applyStimulus(1, 1, 0);
      checkVal("lit resume data", {25'd0, busA.out_data}, 33'hCC);
      repeat (6) applyStimulus(1, 1, 0);
      checkVal("lit stall count", {17'd0, busA.words_drained}, 33'd5);

      // Reset after the second beat discards the word; the next word starts from beat 0.
      fifoQ[0].push_back(32'h87654321);
      repeat (3) applyStimulus(1, 1, 0);
      applyStimulus(1, 1, 1);
      checkVal("lit midreset valid", {32'd0, busA.out_valid}, 33'd0);
      checkVal("lit midreset count", {17'd0, busA.words_drained}, 33'd0);
      fifoQ[0].push_back(32'hDDCCBBAA);
      applyStimulus(1, 1, 0);
      applyStimulus(1, 1, 0);
      checkVal("lit post reset beat0", {25'd0, busA.out_data}, 33'hAA);
      repeat (4) applyStimulus(1, 1, 0);

      // Counter wrap on the 4-bit RATIO=1 build: sixteen pops return it to zero.
      for (int i = 0; i < 16; i++) fifoQ[1].push_back(32'(8'(i * 7 + 3)));
      for (int i = 0; i < 17; i++) begin
         applyStimulus(1, 1, 0);
         if (i == 15) checkVal("lit wrap max", {17'd0, 12'd0, busB.words_drained}, 33'hF);
         if (i == 16) checkVal("lit wrap zero", {17'd0, 12'd0, busB.words_drained}, 33'd0);
      end
      repeat (2) applyStimulus(1, 1, 0);

      // Random pushes, random ready and occasional reset on both builds.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 99) < 15) fifoQ[0].push_back($urandom);
         if ($urandom_range(0, 99) < 50) fifoQ[1].push_back(32'(8'($urandom)));
         applyStimulus($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
                       $urandom_range(0, 299) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
